burst_memory: RTL and testbench
===============================

Name: burst_memory

Overview:
Parametrised single-port synchronous memory. It is the next generation of the team's 16-bit x 1024 valid/WR memory.
- Adds per-byte write enables, multi-beat read bursts with address auto-increment and wrap-around, back-pressure on read data, and an out-of-range error flag.
- Sits behind the bus-side request channel as local scratch storage.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8.
ADDR_W, 10, address width in bits.
DEPTH, 1024, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
LEN_W, 4, burst-length field width; a burst is len+1 beats, so 1..2**LEN_W beats.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
valid  input  1  request valid
ready  output  1  block can accept a request this cycle
WR  input  1  1 = write request, 0 = read request
addr  input  ADDR_W  word address (write address, or start address of a read burst)
data_in  input  DATA_W  write data
byte_en  input  DATA_W/8  per-byte write enable; bit i covers data_in[8i+7:8i]
len  input  LEN_W  read burst length minus one; ignored for writes
data_out  output  DATA_W  read beat data
rd_valid  output  1  data_out holds a valid beat
rd_ready  input  1  consumer accepts the current beat
rd_last  output  1  current beat is the final beat of the burst
err  output  1  one-cycle pulse on an out-of-range request

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: ready=0, rd_valid=0, rd_last=0, data_out=0, err=0, state=IDLE, beat counter=0.
  - Memory array contents are not cleared by reset.
  - ready rises to 1 on the first edge after reset is sampled low.
- Request acceptance: a request is accepted on a rising edge with valid && ready. Inputs are don't-care otherwise.
- States: IDLE and RD_BURST.
  - ready = 1 only in IDLE and not in reset.
- Write, accepted in IDLE with WR=1 and addr < DEPTH:
  - At that edge, each byte i with byte_en[i]=1 of mem[addr] takes the matching data_in byte; other bytes are unchanged.
  - Stay in IDLE with ready=1, so back-to-back writes are possible every cycle.
  - byte_en=0 is a legal no-op write.
- Read, accepted in IDLE with WR=0 and addr < DEPTH:
  - At the accept edge: latch base=addr, last=len, cnt=0. data_out <= mem[addr], rd_valid <= 1, rd_last <= (len==0), state <= RD_BURST, ready <= 0.
  - Read latency is 1 cycle: the first beat is visible the cycle after acceptance.
- RD_BURST beat handshake (edge with rd_valid && rd_ready):
  - Not last beat: cnt++, data_out <= mem[(base+cnt+1) mod DEPTH], rd_last <= (cnt+1 == last).
  - Last beat: rd_valid <= 0, rd_last <= 0, state <= IDLE, ready <= 1. data_out holds its last value.
- Back-pressure: while rd_valid && !rd_ready, data_out, rd_last and cnt hold steady.
- Wrap-around: the beat address increments modulo DEPTH, so a burst starting at DEPTH-1 continues at address 0.
  - The index arithmetic is ADDR_W+1 bits wide, reduced modulo DEPTH; it must not overflow when DEPTH = 2**ADDR_W.
- Out of range (addr >= DEPTH), read or write:
  - The request is consumed with no memory access and no burst.
  - err = 1 for exactly the cycle after acceptance.
  - ready stays 1.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Reset mid-burst: the burst is aborted and all outputs take their reset values on that edge. No further beats are issued after reset deasserts.

Test Plan:
- Reset, then 4 back-to-back writes, byte_en=2'b11: addr 5=16'hA5A5, 35=16'h1234, 25=16'hBEEF, 51=16'h0F0F → ready stays 1 throughout. Single-beat reads (len=0) of each return the written value with rd_last=1, each 1 cycle after acceptance.
- Byte-enable write: write 16'hFFFF to addr 7, then 16'h00AB with byte_en=2'b01 → read of addr 7 returns 16'hFFAB.
- Burst: write addr 10..13 = 1,2,3,4; read addr=10, len=3, rd_ready=1 → data_out 1,2,3,4 on consecutive cycles. rd_last only on beat 4. ready returns to 1 the cycle after beat 4.
- Wrap and back-pressure: DEPTH=1024, write addr 1023=16'h00AA and addr 0=16'h00BB; read addr=1023, len=1 with rd_ready=0 for 3 cycles → 16'h00AA is held 3 cycles, then 16'h00BB follows with rd_last=1.
- Error: with DEPTH=1000, write addr 1000 → err pulses for exactly 1 cycle, memory unchanged. A read of addr 1000 gives err and no rd_valid.
- Reset mid-burst: assert reset during beat 2 of a len=7 burst → rd_valid=0 and ready=0 while reset is high. ready=1 one cycle after release, and no stray beats are issued.

Source files
------------

// File: rtl/burst_memory_if.sv
// Request and read-beat channel of burst_memory.
// master drives requests and rd_ready; slave is the memory side.
interface burst_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 4
);
    logic                  valid;
    logic                  ready;
    logic                  WR;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic [LEN_W-1:0]      len;
    logic [DATA_W-1:0]     data_out;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rd_last;
    logic                  err;

    modport master (
        output valid, WR, addr, data_in, byte_en, len, rd_ready,
        input  ready, data_out, rd_valid, rd_last, err
    );

    modport slave (
        input  valid, WR, addr, data_in, byte_en, len, rd_ready,
        output ready, data_out, rd_valid, rd_last, err
    );
endinterface

// File: rtl/burst_memory.sv
// Single-port scratch memory with byte-enable writes and wrapping multi-beat read bursts.
// Latency: first read beat 1 cycle after accept; rd_ready low holds the current beat and blocks new requests.
module burst_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int LEN_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    burst_memory_if.slave   bus
);
    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, RD_BURST} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    last;
    logic                ready_q;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic                err_q;
    logic [DATA_W-1:0]   dout_q;
    logic                accept;
    logic                in_range;
    logic                wr_en;

    // Compare one bit wider so DEPTH == 2**ADDR_W does not overflow.
    assign in_range = {1'b0, bus.addr} < DEPTH_X;
    assign accept   = bus.valid && ready_q && !reset;
    assign wr_en    = accept && bus.WR && in_range;
    // ptr tracks (base + cnt) mod DEPTH incrementally, so no wide sum is needed.
    assign ptr_nxt  = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.byte_en[i]) begin
                    mem[bus.addr][8*i +: 8] <= bus.data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            dout_q     <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            last       <= '0;
            ptr        <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end else if (!bus.WR) begin
                            ptr        <= bus.addr;
                            last       <= bus.len;
                            cnt        <= '0;
                            dout_q     <= mem[bus.addr];
                            rd_valid_q <= 1'b1;
                            rd_last_q  <= (bus.len == '0);
                            ready_q    <= 1'b0;
                            state      <= RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_valid_q && bus.rd_ready) begin
                        if (cnt == last) begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            ready_q    <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt       <= cnt + LEN_W'(1);
                            ptr       <= ptr_nxt;
                            dout_q    <= mem[ptr_nxt];
                            rd_last_q <= ((cnt + LEN_W'(1)) == last);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.data_out = dout_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_burst_memory.sv
// Directed bench: full-depth instance for data paths, DEPTH=1000 instance for range errors.
module tb_burst_memory;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    burst_memory_if #(.DATA_W(16), .ADDR_W(10), .LEN_W(4)) b0 ();
    burst_memory_if #(.DATA_W(16), .ADDR_W(10), .LEN_W(4)) b1 ();

    burst_memory #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .LEN_W(4)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    burst_memory #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .LEN_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        b0.valid = 1'b1; b0.WR = 1'b1; b0.addr = a; b0.data_in = d; b0.byte_en = be;
        tick();
        b0.valid = 1'b0;
        chk("wr_ready", {31'd0, b0.ready}, 32'd1);
    endtask

    task automatic rd1(input logic [9:0] a, input logic [15:0] exp);
        b0.valid = 1'b1; b0.WR = 1'b0; b0.addr = a; b0.len = 4'd0; b0.rd_ready = 1'b1;
        tick();
        b0.valid = 1'b0;
        chk("rd1_valid", {31'd0, b0.rd_valid}, 32'd1);
        chk("rd1_data", {16'd0, b0.data_out}, {16'd0, exp});
        chk("rd1_last", {31'd0, b0.rd_last}, 32'd1);
        chk("rd1_busy", {31'd0, b0.ready}, 32'd0);
        tick();
        chk("rd1_done_valid", {31'd0, b0.rd_valid}, 32'd0);
        chk("rd1_done_ready", {31'd0, b0.ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        b0.valid = 1'b0; b0.WR = 1'b0; b0.addr = '0; b0.data_in = '0;
        b0.byte_en = '0; b0.len = '0; b0.rd_ready = 1'b1;
        b1.valid = 1'b0; b1.WR = 1'b0; b1.addr = '0; b1.data_in = '0;
        b1.byte_en = '0; b1.len = '0; b1.rd_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", {31'd0, b0.ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, b0.rd_valid}, 32'd0);
        chk("rst_rd_last", {31'd0, b0.rd_last}, 32'd0);
        chk("rst_data_out", {16'd0, b0.data_out}, 32'd0);
        chk("rst_err", {31'd0, b0.err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, b0.ready}, 32'd1);

        // Back-to-back writes then single-beat reads
        wr0(10'd5,  16'hA5A5, 2'b11);
        wr0(10'd35, 16'h1234, 2'b11);
        wr0(10'd25, 16'hBEEF, 2'b11);
        wr0(10'd51, 16'h0F0F, 2'b11);
        rd1(10'd5,  16'hA5A5);
        rd1(10'd35, 16'h1234);
        rd1(10'd25, 16'hBEEF);
        rd1(10'd51, 16'h0F0F);

        // Low byte only; read immediately after the write
        wr0(10'd7, 16'hFFFF, 2'b11);
        wr0(10'd7, 16'h00AB, 2'b01);
        rd1(10'd7, 16'hFFAB);
        wr0(10'd8, 16'h1111, 2'b11);
        wr0(10'd8, 16'h2222, 2'b00);
        rd1(10'd8, 16'h1111);

        // Four-beat burst
        for (int i = 0; i < 4; i++) wr0(10'(10 + i), 16'(i + 1), 2'b11);
        b0.valid = 1'b1; b0.WR = 1'b0; b0.addr = 10'd10; b0.len = 4'd3; b0.rd_ready = 1'b1;
        tick();
        b0.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("burst_data", {16'd0, b0.data_out}, 32'(i + 1));
            chk("burst_valid", {31'd0, b0.rd_valid}, 32'd1);
            chk("burst_last", {31'd0, b0.rd_last}, (i == 3) ? 32'd1 : 32'd0);
            chk("burst_ready", {31'd0, b0.ready}, 32'd0);
            tick();
        end
        chk("burst_end_valid", {31'd0, b0.rd_valid}, 32'd0);
        chk("burst_end_ready", {31'd0, b0.ready}, 32'd1);

        // Wrap from 1023 to 0 with back-pressure on the first beat
        wr0(10'd1023, 16'h00AA, 2'b11);
        wr0(10'd0,    16'h00BB, 2'b11);
        b0.valid = 1'b1; b0.WR = 1'b0; b0.addr = 10'd1023; b0.len = 4'd1; b0.rd_ready = 1'b0;
        tick();
        b0.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_data", {16'd0, b0.data_out}, 32'h00AA);
            chk("bp_valid", {31'd0, b0.rd_valid}, 32'd1);
            chk("bp_last", {31'd0, b0.rd_last}, 32'd0);
            if (i == 2) b0.rd_ready = 1'b1;
            tick();
        end
        chk("wrap_data", {16'd0, b0.data_out}, 32'h00BB);
        chk("wrap_valid", {31'd0, b0.rd_valid}, 32'd1);
        chk("wrap_last", {31'd0, b0.rd_last}, 32'd1);
        tick();
        chk("wrap_end_valid", {31'd0, b0.rd_valid}, 32'd0);
        chk("wrap_end_ready", {31'd0, b0.ready}, 32'd1);

        // Out-of-range on the DEPTH=1000 instance
        b1.valid = 1'b1; b1.WR = 1'b1; b1.addr = 10'd0; b1.data_in = 16'h5555; b1.byte_en = 2'b11;
        tick();
        b1.addr = 10'd1000; b1.data_in = 16'h1234;
        tick();
        b1.valid = 1'b0;
        chk("oor_wr_err", {31'd0, b1.err}, 32'd1);
        chk("oor_wr_ready", {31'd0, b1.ready}, 32'd1);
        tick();
        chk("oor_wr_err_clear", {31'd0, b1.err}, 32'd0);
        b1.valid = 1'b1; b1.WR = 1'b0; b1.addr = 10'd0; b1.len = 4'd0;
        tick();
        b1.valid = 1'b0;
        chk("oor_mem_kept", {16'd0, b1.data_out}, 32'h5555);
        chk("oor_mem_kept_err", {31'd0, b1.err}, 32'd0);
        tick();
        b1.valid = 1'b1; b1.WR = 1'b0; b1.addr = 10'd1000; b1.len = 4'd2;
        tick();
        b1.valid = 1'b0;
        chk("oor_rd_err", {31'd0, b1.err}, 32'd1);
        chk("oor_rd_no_valid", {31'd0, b1.rd_valid}, 32'd0);
        chk("oor_rd_ready", {31'd0, b1.ready}, 32'd1);
        tick();
        chk("oor_rd_err_clear", {31'd0, b1.err}, 32'd0);
        chk("oor_rd_still_no_valid", {31'd0, b1.rd_valid}, 32'd0);

        // Reset during beat 2 of an eight-beat burst
        b0.valid = 1'b1; b0.WR = 1'b0; b0.addr = 10'd10; b0.len = 4'd7; b0.rd_ready = 1'b1;
        tick();
        b0.valid = 1'b0;
        chk("mid_beat1", {16'd0, b0.data_out}, 32'd1);
        tick();
        chk("mid_beat2", {16'd0, b0.data_out}, 32'd2);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid_rst_valid", {31'd0, b0.rd_valid}, 32'd0);
            chk("mid_rst_ready", {31'd0, b0.ready}, 32'd0);
            chk("mid_rst_last", {31'd0, b0.rd_last}, 32'd0);
            chk("mid_rst_data", {16'd0, b0.data_out}, 32'd0);
        end
        reset = 1'b0;
        tick();
        chk("mid_rel_ready", {31'd0, b0.ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_stray", {31'd0, b0.rd_valid}, 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
